mem_access_unit: RTL and testbench

- Requester-side load/store unit between the CPU datapath and the word-wide data memory port (mRD/mWR/DAddr/DataIn/DataOut).
- Accepts byte, halfword and word loads/stores from the CPU and drives only word-aligned, full-word accesses to memory.
- Sub-word stores are performed as read-modify-write.
- Loads are extracted with sign or zero extension; misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/mem_access_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Requester-side load/store unit sitting between the CPU
//                datapath and a word-wide data memory port. It turns
//                byte/half/word loads and stores into word-aligned full-word
//                memory accesses. Sub-word stores are done as read-modify-
//                write, and loads are sign- or zero-extended. Misaligned or
//                out-of-range requests are rejected without a memory access.
//
//  Ports       : CLK      - clock, rising edge
//                Reset    - asynchronous active-low reset
//                req      - CPU request, sampled only when idle
//                we       - 1 = store, 0 = load
//                size     - 00 byte, 01 half, 10 word, 11 illegal
//                sext     - loads: 1 = sign-extend, 0 = zero-extend
//                addr     - byte address
//                wdata    - store data, right-aligned
//                rdata    - load result, valid with done
//                busy     - set at accept, cleared together with done
//                done     - one-cycle completion pulse
//                err      - rejected request, valid with done
//                mRD/mWR  - memory read / write enables
//                DAddr    - word-aligned memory address
//                DataIn   - memory write data
//                DataOut  - memory read data (combinational from DAddr)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int MEM_BYTES = 256
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mRD,
   output logic        mWR,
   output logic [31:0] DAddr,
   output logic [31:0] DataIn,
   input  logic [31:0] DataOut
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Extract a byte/half/word from a memory word (little endian).
   function automatic logic [31:0] f_extract(input logic [31:0] word,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane,
                                             input logic        sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = {{24{sx & b[7]}}, b};
         2'b01:   r = {{16{sx & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte or half of a memory word with store data.
   function automatic logic [31:0] f_merge(input logic [31:0] word,
                                           input logic [15:0] wd,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  lane);
      logic [31:0] r;
      r = word;
      if (sz == 2'b00) begin
         r[{lane, 3'b000} +: 8] = wd[7:0];
      end else begin
         r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [1:0]  lane_q, lane_d;
   // Only the low half of store data is needed after accept: word stores
   // load DataIn straight from the request.
   logic [15:0] wlow_q, wlow_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mrd_q, mrd_d;
   logic        mwr_q, mwr_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] datain_q, datain_d;

   // Last byte touched by the aligned word; 33 bits so the top word of the
   // address space cannot wrap around and look legal.
   logic [32:0] w_last;
   logic        w_err;

   assign w_last = {1'b0, addr[31:2], 2'b00} + 33'd3;
   assign w_err  = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (addr[1:0] != 2'b00))
                 | (w_last > 33'(MEM_BYTES - 1));

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         sext_q   <= 1'b0;
         lane_q   <= 2'b00;
         wlow_q   <= 16'h0;
         rdata_q  <= 32'h0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
         daddr_q  <= 32'h0;
         datain_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sext_q   <= sext_d;
         lane_q   <= lane_d;
         wlow_q   <= wlow_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
         daddr_q  <= daddr_d;
         datain_q <= datain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      sext_d   = sext_q;
      lane_d   = lane_q;
      wlow_d   = wlow_q;
      rdata_d  = rdata_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      mrd_d    = 1'b0;
      mwr_d    = 1'b0;
      daddr_d  = daddr_q;
      datain_d = datain_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d   = we;
               size_d = size;
               sext_d = sext;
               lane_d = addr[1:0];
               wlow_d = wdata[15:0];
               busy_d = 1'b1;
               if (w_err) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  daddr_d = {addr[31:2], 2'b00};
                  if (we && (size == 2'b10)) begin
                     mwr_d    = 1'b1;
                     datain_d = wdata;
                     state_d  = S_WRITE;
                  end else begin
                     mrd_d   = 1'b1;
                     state_d = S_READ;
                  end
               end
            end
         end

         S_READ: begin
            if (we_q) begin
               // The merged word is formed from the read data at this edge
               // so it is already stable for the whole write cycle.
               mwr_d    = 1'b1;
               datain_d = f_merge(DataOut, wlow_q, size_q, lane_q);
               state_d  = S_WRITE;
            end else begin
               rdata_d = f_extract(DataOut, size_q, lane_q, sext_q);
               done_d  = 1'b1;
               state_d = S_RESP;
            end
         end

         S_WRITE: begin
            done_d  = 1'b1;
            state_d = S_RESP;
         end

         S_RESP: begin
            // A rejected request arrives here with done still low and waits
            // one cycle, so it completes with the same latency as a load.
            if (done_q) begin
               busy_d  = 1'b0;
               err_d   = 1'b0;
               rdata_d = 32'h0;
               state_d = S_IDLE;
            end else begin
               done_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign rdata  = rdata_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign mRD    = mrd_q;
   assign mWR    = mwr_q;
   assign DAddr  = daddr_q;
   assign DataIn = datain_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. A word-wide memory
//                is attached to the memory port; a byte-array reference
//                model predicts load results, merged store words, error
//                flags and completion latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   localparam int MEM_BYTES = 256;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        req, we, sext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] rdata, DAddr, DataIn, DataOut;
   logic        busy, done, err, mRD, mWR;

   logic [31:0] dut_mem [64];
   logic [7:0]  ref_mem [MEM_BYTES];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   mem_access_unit #(.MEM_BYTES(MEM_BYTES)) u_dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .req     (req),
      .we      (we),
      .size    (size),
      .sext    (sext),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .mRD     (mRD),
      .mWR     (mWR),
      .DAddr   (DAddr),
      .DataIn  (DataIn),
      .DataOut (DataOut)
   );

   // Memory: combinational read, write on the falling edge.
   assign DataOut = (mRD && (DAddr < 32'(MEM_BYTES))) ? dut_mem[DAddr[7:2]] : 32'h0;

   always @(negedge CLK) begin
      if (mWR && (DAddr < 32'(MEM_BYTES))) dut_mem[DAddr[7:2]] <= DataIn;
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
      int i;
      logic [31:0] v;
      i = int'(a[7:0]);
      case (sz)
         2'b00: begin
            v = {24'h0, ref_mem[i]};
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'b01: begin
            v = {16'h0, ref_mem[i+1], ref_mem[i]};
            if (sx && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
      endcase
      return v;
   endfunction

   function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
      longint last;
      last = longint'(a & 32'hFFFF_FFFC) + 3;
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00) || (last > MEM_BYTES - 1);
   endfunction

   // One complete request, checked against the reference model.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      logic        e, got_done;
      logic [31:0] exp_rd, rd_addr, wr_addr, wr_data, exp_word;
      int          exp_lat, exp_nrd, exp_nwr, nrd, nwr, nboth, cyc, base;

      e       = ref_err(a, sz);
      exp_rd  = 32'h0;
      exp_lat = 2;
      exp_nrd = 0;
      exp_nwr = 0;
      if (!e) begin
         if (!w) begin
            exp_nrd = 1;
            exp_rd  = ref_load(a, sz, sx);
         end else begin
            exp_nwr = 1;
            if (sz != 2'b10) begin
               exp_nrd = 1;
               exp_lat = 3;
            end
         end
      end

      @(negedge CLK);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(posedge CLK);
      #1;
      // Scramble the request inputs: the unit must work from its own copy.
      req = 1'b0; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      chk_eq("busy_at_accept", 32'(busy), 32'd1);

      nrd = 0; nwr = 0; nboth = 0; cyc = 0; got_done = 1'b0;
      rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0;
      while (!got_done && cyc < 8) begin
         @(negedge CLK);
         cyc++;
         if (mRD) begin nrd++; rd_addr = DAddr; end
         if (mWR) begin nwr++; wr_addr = DAddr; wr_data = DataIn; end
         if (mRD && mWR) nboth++;
         if (done) got_done = 1'b1;
      end

      chk_eq("latency", 32'(cyc), 32'(exp_lat));
      chk_eq("err", 32'(err), 32'(e));
      chk_eq("rdata", rdata, exp_rd);
      chk_eq("read_cycles", 32'(nrd), 32'(exp_nrd));
      chk_eq("write_cycles", 32'(nwr), 32'(exp_nwr));
      chk_eq("rd_wr_overlap", 32'(nboth), 32'd0);
      chk_eq("busy_at_done", 32'(busy), 32'd1);
      if (exp_nrd != 0) chk_eq("read_addr", rd_addr, a & 32'hFFFF_FFFC);
      if (exp_nwr != 0) begin
         base = int'({a[7:2], 2'b00});
         case (sz)
            2'b00: ref_mem[int'(a[7:0])] = wd[7:0];
            2'b01: begin
               ref_mem[int'(a[7:0])]     = wd[7:0];
               ref_mem[int'(a[7:0]) + 1] = wd[15:8];
            end
            default: for (int k = 0; k < 4; k++) ref_mem[base + k] = wd[8*k +: 8];
         endcase
         exp_word = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
         chk_eq("write_addr", wr_addr, a & 32'hFFFF_FFFC);
         chk_eq("write_data", wr_data, exp_word);
      end

      @(posedge CLK);
      #1;
      chk_eq("done_falls", 32'(done), 32'd0);
      chk_eq("busy_falls", 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_rdata"},  rdata, 32'h0);
      chk_eq({tag, "_busy"},   32'(busy), 32'd0);
      chk_eq({tag, "_done"},   32'(done), 32'd0);
      chk_eq({tag, "_err"},    32'(err), 32'd0);
      chk_eq({tag, "_mRD"},    32'(mRD), 32'd0);
      chk_eq({tag, "_mWR"},    32'(mWR), 32'd0);
      chk_eq({tag, "_DAddr"},  DAddr, 32'h0);
      chk_eq({tag, "_DataIn"}, DataIn, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      int          nd, nmrd, nidle, bad, r;
      logic [31:0] exp_hs, ra;
      logic [1:0]  rs;

      Reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      @(negedge CLK);
      Reset = 1'b1;

      // Fill the whole memory through the unit.
      for (int i = 0; i < MEM_BYTES / 4; i++) do_op(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

      // Word store then load, byte RMW.
      do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      do_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h55);
      do_op(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
      chk_eq("sb_merge_mem", dut_mem[4], 32'hDE55BEEF);

      // Sub-word loads.
      do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h8091A2B3);
      do_op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
      do_op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
      do_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
      do_op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
      do_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234CAFE);

      // Rejected requests and the top-of-memory boundary.
      do_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
      do_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0);
      do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
      do_op(1'b1, 2'b10, 1'b0, 32'hFC, 32'hA5A5_5A5A);
      do_op(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      do_op(1'b1, 2'b00, 1'b0, 32'h100, 32'h77);
      do_op(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         r  = int'($urandom_range(0, 9));
         rs = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 263));
         do_op(1'($urandom), rs, 1'($urandom), ra, $urandom);
      end

      // req held high: one access per idle visit, none while busy.
      exp_hs = ref_load(32'h10, 2'b10, 1'b0);
      nd = 0; nmrd = 0; nidle = 0; bad = 0;
      @(negedge CLK);
      req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10; wdata = 32'h0;
      repeat (30) begin
         @(negedge CLK);
         if (done) begin
            nd++;
            if (rdata !== exp_hs || !busy) bad++;
         end
         if (mRD) nmrd++;
         if (!busy) nidle++;
      end
      req = 1'b0;
      chk_eq("hs_done_count", 32'(nd), 32'd10);
      chk_eq("hs_read_count", 32'(nmrd), 32'd10);
      chk_eq("hs_idle_count", 32'(nidle), 32'd10);
      chk_eq("hs_bad_resp", 32'(bad), 32'd0);

      // Reset while the write of a byte store is in flight.
      @(negedge CLK);
      req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h12; wdata = 32'hAA;
      @(posedge CLK);
      #1 req = 1'b0;
      @(posedge CLK);
      #1;
      chk_eq("rst_in_write", 32'(mWR), 32'd1);
      Reset = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (2) @(negedge CLK);
      Reset = 1'b1;
      do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      do_op(1'b1, 2'b00, 1'b0, 32'h12, 32'hAA);
      do_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);

      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
